fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Schedules the single write port of the TX FIFO between the two response producers of the system: the 16-bit ALU result and the 8-bit register-file read data. Sits in the REF_CLK domain between SYS_CTRL/ALU/REG_FILE and the FIFO write side. It captures each response, serialises the ALU result into two bytes, and pushes bytes only while the FIFO is not full. Round-robin arbitration resolves contention.

## Interface
- DATA_WIDTH, 8, FIFO byte width and read-data width
- ALU_OUT_WIDTH, 16, ALU result width; must equal 2*DATA_WIDTH
- CLK  in  1  REF_CLK domain clock; all logic rising-edge
- RST  in  1  reset; asynchronous assertion, active-low (0 = reset)
- ALU_OUT  in  ALU_OUT_WIDTH  ALU result, sampled when ALU_VLD=1
- ALU_VLD  in  1  one-cycle pulse marking a new ALU result
- RD_DATA  in  DATA_WIDTH  register-file read data, sampled when RD_VLD=1
- RD_VLD  in  1  one-cycle pulse marking new read data
- FIFO_FULL  in  1  FIFO write-side full flag
- TX_P_DATA  out  DATA_WIDTH  byte presented to the FIFO
- W_INC  out  1  FIFO write strobe; one byte per high cycle
- BUSY  out  1  high while any captured response has not been fully pushed; SYS_CTRL must not issue a new command while it is high
- OVR_CNT  out  8  overrun counter; present only with ARB_OVR_CNT_EN

## Operation
- Two capture slots:
  - ALU slot: 16-bit register plus pending flag.
  - RD slot: 8-bit register plus pending flag.
- Capture rules:
  - A valid pulse on a slot whose pending flag is 0 loads the data and sets pending.
  - A valid pulse on a slot whose pending flag is 1 is an overrun. The new data is discarded and the held data is unchanged.
  - ALU_VLD and RD_VLD together in one cycle: both are captured independently.
- FSM states: IDLE, SEND_RD, SEND_ALU_LO, SEND_ALU_HI.
  - IDLE: no pending flag set → stay in IDLE.
  - IDLE: only one flag set → go to that slot's send state (SEND_RD or SEND_ALU_LO).
  - IDLE: both flags set → grant the slot not served last. last_grant resets to RD, so the first tie goes to ALU.
  - SEND_RD: TX_P_DATA = RD slot data.
  - SEND_ALU_LO: TX_P_DATA = ALU slot [7:0].
  - SEND_ALU_HI: TX_P_DATA = ALU slot [15:8]. Byte order is always LSB first.
- Push rule, in any SEND_* state:
  - W_INC = !FIFO_FULL, combinational from the registered state and FIFO_FULL.
  - The state advances only on a cycle where W_INC=1. FIFO_FULL=1 holds the state and data indefinitely.
- Completion:
  - Push in SEND_ALU_LO → SEND_ALU_HI.
  - Push in SEND_RD or SEND_ALU_HI → clear that slot's pending flag, update last_grant, go to IDLE.
- A slot stays pending until its last byte is pushed. A valid on that slot during its own transmission is therefore an overrun.
- BUSY = ALU pending | RD pending.
- Reset values:
  - State IDLE; both pending flags 0; slot data 0; last_grant = RD.
  - W_INC 0; TX_P_DATA 0; BUSY 0; OVR_CNT 0.
- Reset mid-operation: a partially sent ALU result is abandoned. No further bytes of it are pushed after reset is released.

## Timing
- A valid in cycle 0 is captured at the end of cycle 0.
- Cycle 1: IDLE grants; the state register updates at the end of cycle 1.
- Cycle 2: first W_INC, if FIFO_FULL=0.
- ALU result: bytes in cycles 2 and 3 when not full, so BUSY falls at the end of cycle 3. RD: BUSY falls at the end of cycle 2.
- Back-to-back responses have a minimum of one IDLE cycle between frames.
- No push is ever made in a cycle where FIFO_FULL=1.

## Configuration
- Macro: ARB_OVR_CNT_EN.
- Defined:
  - OVR_CNT port and an 8-bit counter exist.
  - Counter increments by 1 per dropped valid, counting each source separately, so simultaneous drops on both slots add 2.
  - Saturates at 255; cleared only by reset.
- Undefined: port and counter are absent; overruns are dropped silently. All other behaviour is identical.

## Structure
- Package fifo_wr_arb_pkg holds:
  - the state enum (IDLE, SEND_RD, SEND_ALU_LO, SEND_ALU_HI);
  - grant encoding constants (GNT_ALU, GNT_RD);
  - the overrun counter width and maximum (8, 255).
- Sub-module rr_arb2: 2-requester round-robin with a last_grant register, updated on a completion strobe. Its state is the only state outside the top FSM.

## Test plan
- RD_VLD with RD_DATA=0x5A, FIFO_FULL=0 → W_INC in cycle 2 with TX_P_DATA=0x5A; BUSY high in cycles 1–2, then low.
- ALU_VLD with ALU_OUT=0x1234 → pushes 0x34 then 0x12 in consecutive cycles; exactly two W_INC pulses.
- ALU_VLD and RD_VLD together (0xBEEF, 0x77) right after reset:
  - pushes 0xEF, 0xBE, one idle cycle, then 0x77;
  - a repeat of the same pair serves RD first.
- ALU_OUT=0xA55A, with FIFO_FULL held high from cycle 2 for 5 cycles → no W_INC while full; 0x5A then 0xA5 pushed after release; data stable throughout.
- ALU_VLD again while ALU is pending, with ARB_OVR_CNT_EN defined → OVR_CNT=1 and the original result is pushed unchanged. 300 overruns → OVR_CNT=255.
- RST low during SEND_ALU_HI → all outputs return to 0 immediately, and no high byte is pushed after release.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
// ----------------------------------------------------------------------------
// fifo_wr_arb_pkg
//   Shared definitions for the TX FIFO write-port arbiter:
//   - arb_state_e   : top FSM states
//   - GNT_ALU/GNT_RD: 1-bit grant encoding used by rr_arb2 and the top
//   - OVR_CNT_W/MAX : overrun counter width and saturation value
//   - sat_add()     : saturating add used by the optional overrun counter
// ----------------------------------------------------------------------------
package fifo_wr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_RD     = 2'd1,
        SEND_ALU_LO = 2'd2,
        SEND_ALU_HI = 2'd3
    } arb_state_e;

    localparam logic GNT_ALU = 1'b1;
    localparam logic GNT_RD  = 1'b0;

    localparam int                   OVR_CNT_W   = 8;
    localparam logic [OVR_CNT_W-1:0] OVR_CNT_MAX = 8'd255;

    // Adds 0..2 to the counter, clamping at OVR_CNT_MAX. One bit of headroom
    // in the sum is enough because the increment never exceeds 2.
    function automatic logic [OVR_CNT_W-1:0] sat_add(input logic [OVR_CNT_W-1:0] cnt,
                                                     input logic [1:0]           inc);
        logic [OVR_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(OVR_CNT_W-1){1'b0}}, inc};
        return (sum > {1'b0, OVR_CNT_MAX}) ? OVR_CNT_MAX : sum[OVR_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
//   Two-requester round-robin arbiter. On a tie the requester that was not
//   served last wins. last_grant only moves on a completion strobe, so a
//   frame that stalls on a full FIFO does not disturb the fairness order.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_alu      : ALU slot pending
//   req_rd       : RD slot pending
//   done         : a frame finished this cycle (last byte pushed)
//   done_gnt     : which slot finished (GNT_ALU / GNT_RD)
//   gnt          : combinational grant (meaningful when any request is set)
// ----------------------------------------------------------------------------
module rr_arb2
    import fifo_wr_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_alu,
    input  logic req_rd,
    input  logic done,
    input  logic done_gnt,
    output logic gnt
);

    logic last_grant;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_RD;   // first tie after reset goes to the ALU
        end else if (done) begin
            last_grant <= done_gnt;
        end
    end

    // NOTE: combinational blocks assign a default first so no path leaves the
    // output unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt = GNT_ALU;
        if (req_alu && req_rd) begin
            gnt = (last_grant == GNT_ALU) ? GNT_RD : GNT_ALU;
        end else if (req_rd) begin
            gnt = GNT_RD;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the single TX FIFO write port between the 16-bit ALU result and
//   the 8-bit register-file read data. Each response is captured into its own
//   slot, then pushed byte by byte (ALU result LSB first) while the FIFO is
//   not full. Ties between pending slots are resolved round-robin (rr_arb2).
//
// Configuration
//   ARB_OVR_CNT_EN : when defined, adds the OVR_CNT port and a saturating
//                    8-bit count of valids dropped because their slot was
//                    still pending. When undefined, such valids are dropped
//                    silently.
//
// Ports
//   CLK        : REF_CLK, rising edge
//   RST        : asynchronous active-low reset
//   ALU_OUT    : ALU result, sampled when ALU_VLD=1
//   ALU_VLD    : one-cycle pulse, new ALU result
//   RD_DATA    : register-file read data, sampled when RD_VLD=1
//   RD_VLD     : one-cycle pulse, new read data
//   FIFO_FULL  : FIFO write-side full flag
//   TX_P_DATA  : byte presented to the FIFO (0 while idle)
//   W_INC      : write strobe, one byte per high cycle
//   BUSY       : some captured response has not been fully pushed
//   OVR_CNT    : overrun counter (ARB_OVR_CNT_EN only)
//
//   ALU_OUT_WIDTH must equal 2*DATA_WIDTH; the ALU slot is split into two
//   DATA_WIDTH halves.
// ----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_VLD,
    input  logic [DATA_WIDTH-1:0]    RD_DATA,
    input  logic                     RD_VLD,
    input  logic                     FIFO_FULL,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     W_INC,
    output logic                     BUSY
`ifdef ARB_OVR_CNT_EN
    ,
    output logic [OVR_CNT_W-1:0]     OVR_CNT
`endif
);

    arb_state_e               state_q, state_nxt;
    logic [ALU_OUT_WIDTH-1:0] alu_data;
    logic [DATA_WIDTH-1:0]    rd_data_q;
    logic                     alu_pend, rd_pend;
    logic                     alu_cap, rd_cap;
    logic                     alu_done, rd_done;
    logic                     gnt;

    // A valid is only accepted into an empty slot; a valid on a pending slot
    // (including one still being transmitted) is an overrun and is dropped.
    assign alu_cap = ALU_VLD && !alu_pend;
    assign rd_cap  = RD_VLD  && !rd_pend;

    // Push strobe depends only on the registered state and FIFO_FULL, so no
    // byte is ever written while the FIFO reports full.
    assign W_INC    = (state_q != IDLE) && !FIFO_FULL;
    assign alu_done = W_INC && (state_q == SEND_ALU_HI);
    assign rd_done  = W_INC && (state_q == SEND_RD);
    assign BUSY     = alu_pend || rd_pend;

    rr_arb2 u_rr_arb2 (
        .clk      (CLK),
        .rst_n    (RST),
        .req_alu  (alu_pend),
        .req_rd   (rd_pend),
        .done     (alu_done || rd_done),
        .done_gnt (alu_done ? GNT_ALU : GNT_RD),
        .gnt      (gnt)
    );

    // NOTE: the slot data registers are reset even though pending gates their
    // use; it keeps TX_P_DATA and the slots deterministic from reset onward.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            alu_pend  <= 1'b0;
            rd_pend   <= 1'b0;
            alu_data  <= '0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_nxt;
            if (alu_cap) alu_data  <= ALU_OUT;
            if (rd_cap)  rd_data_q <= RD_DATA;
            // Capture and completion never coincide on one slot: capture
            // needs pending=0, completion needs pending=1.
            alu_pend <= (alu_pend && !alu_done) || alu_cap;
            rd_pend  <= (rd_pend  && !rd_done)  || rd_cap;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE: begin
                if (alu_pend || rd_pend)
                    state_nxt = (gnt == GNT_ALU) ? SEND_ALU_LO : SEND_RD;
            end
            SEND_RD:     if (W_INC) state_nxt = IDLE;
            SEND_ALU_LO: if (W_INC) state_nxt = SEND_ALU_HI;
            SEND_ALU_HI: if (W_INC) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        TX_P_DATA = '0;
        unique case (state_q)
            SEND_RD:     TX_P_DATA = rd_data_q;
            SEND_ALU_LO: TX_P_DATA = alu_data[DATA_WIDTH-1:0];
            SEND_ALU_HI: TX_P_DATA = alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
            default:     TX_P_DATA = '0;
        endcase
    end

`ifdef ARB_OVR_CNT_EN
    logic [1:0] ovr_inc;

    // Each source is counted on its own, so a simultaneous drop adds 2.
    assign ovr_inc = {1'b0, ALU_VLD && alu_pend} + {1'b0, RD_VLD && rd_pend};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OVR_CNT <= '0;
        end else begin
            OVR_CNT <= sat_add(OVR_CNT, ovr_inc);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter. Inputs change 1 time unit after the
//   rising edge; outputs are checked on the falling edge. "cN" in comments is
//   the cycle count from the cycle in which the valid is driven (c0).
//   Pushed bytes are logged on the falling edge when W_INC=1.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] alu_out;
    logic        alu_vld;
    logic [7:0]  rd_data;
    logic        rd_vld;
    logic        fifo_full;
    logic [7:0]  tx_p_data;
    logic        w_inc;
    logic        busy;
`ifdef ARB_OVR_CNT_EN
    logic [7:0]  ovr_cnt;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0] push_log[$];
    logic [7:0] exp_q[$];

    fifo_wr_arbiter #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(16)) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .ALU_OUT   (alu_out),
        .ALU_VLD   (alu_vld),
        .RD_DATA   (rd_data),
        .RD_VLD    (rd_vld),
        .FIFO_FULL (fifo_full),
        .TX_P_DATA (tx_p_data),
        .W_INC     (w_inc),
        .BUSY      (busy)
`ifdef ARB_OVR_CNT_EN
        ,
        .OVR_CNT   (ovr_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && w_inc) push_log.push_back(tx_p_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_count"}, push_log.size(), exp_q.size());
        foreach (exp_q[i]) begin
            chk($sformatf("%s_byte%0d", tag, i),
                (i < push_log.size()) ? {24'h0, push_log[i]} : 32'hxxxx_xxxx,
                {24'h0, exp_q[i]});
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Leaves the bench at posedge+1 of the first cycle with reset released.
    task automatic do_reset();
        rst_n     = 1'b0;
        alu_vld   = 1'b0;
        rd_vld    = 1'b0;
        alu_out   = '0;
        rd_data   = '0;
        fifo_full = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        push_log.delete();
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0; alu_vld = 1'b0; rd_vld = 1'b0;
        alu_out = '0; rd_data = '0; fifo_full = 1'b0;
        #2;
        chk("rst_w_inc", w_inc, 0);
        chk("rst_tx",    tx_p_data, 0);
        chk("rst_busy",  busy, 0);
`ifdef ARB_OVR_CNT_EN
        chk("rst_ovr",   ovr_cnt, 0);
`endif
        do_reset();

        // ---------------- T1: single RD 0x5A ----------------
        rd_vld = 1'b1; rd_data = 8'h5A;                  // c0
        mid(); chk("t1_c0_busy", busy, 0);
        cyc(); rd_vld = 1'b0;                            // c1
        mid(); chk("t1_c1_busy", busy, 1); chk("t1_c1_winc", w_inc, 0);
        cyc();                                           // c2
        mid(); chk("t1_c2_winc", w_inc, 1); chk("t1_c2_tx", tx_p_data, 8'h5A);
        chk("t1_c2_busy", busy, 1);
        cyc();                                           // c3
        mid(); chk("t1_c3_busy", busy, 0); chk("t1_c3_winc", w_inc, 0);
        exp_q = '{8'h5A}; chk_log("t1_log");

        // ---------------- T2: ALU 0x1234, LSB first ----------------
        cyc(); push_log.delete();
        alu_vld = 1'b1; alu_out = 16'h1234;              // c0
        cyc(); alu_vld = 1'b0;                           // c1
        mid(); chk("t2_c1_busy", busy, 1); chk("t2_c1_winc", w_inc, 0);
        cyc();                                           // c2
        mid(); chk("t2_c2_winc", w_inc, 1); chk("t2_c2_tx", tx_p_data, 8'h34);
        cyc();                                           // c3
        mid(); chk("t2_c3_winc", w_inc, 1); chk("t2_c3_tx", tx_p_data, 8'h12);
        cyc();                                           // c4
        mid(); chk("t2_c4_busy", busy, 0); chk("t2_c4_winc", w_inc, 0);
        cyc(); cyc();
        exp_q = '{8'h34, 8'h12}; chk_log("t2_log");

        // ---------------- T3: simultaneous pair after reset ----------------
        do_reset();
        alu_vld = 1'b1; alu_out = 16'hBEEF;
        rd_vld  = 1'b1; rd_data = 8'h77;                 // c0
        cyc(); alu_vld = 1'b0; rd_vld = 1'b0;            // c1
        mid(); chk("t3_c1_winc", w_inc, 0);
        cyc();                                           // c2: tie goes to ALU
        mid(); chk("t3_c2_winc", w_inc, 1); chk("t3_c2_tx", tx_p_data, 8'hEF);
        cyc();                                           // c3
        mid(); chk("t3_c3_winc", w_inc, 1); chk("t3_c3_tx", tx_p_data, 8'hBE);
        cyc();                                           // c4: idle gap
        mid(); chk("t3_c4_winc", w_inc, 0); chk("t3_c4_busy", busy, 1);
        cyc();                                           // c5
        mid(); chk("t3_c5_winc", w_inc, 1); chk("t3_c5_tx", tx_p_data, 8'h77);
        cyc();                                           // c6
        mid(); chk("t3_c6_busy", busy, 0);
        exp_q = '{8'hEF, 8'hBE, 8'h77}; chk_log("t3_log");

        // ALU-only frame, so ALU is the last slot served; the next tie
        // must then go to RD.
        cyc(); push_log.delete();
        alu_vld = 1'b1; alu_out = 16'h1111;              // c0
        cyc(); alu_vld = 1'b0;
        repeat (4) cyc();                                // c5, idle again
        mid(); chk("t3b_idle_busy", busy, 0);
        cyc(); push_log.delete();
        alu_vld = 1'b1; alu_out = 16'hBEEF;
        rd_vld  = 1'b1; rd_data = 8'h77;                 // c0
        cyc(); alu_vld = 1'b0; rd_vld = 1'b0;            // c1
        cyc();                                           // c2: RD first
        mid(); chk("t3b_c2_winc", w_inc, 1); chk("t3b_c2_tx", tx_p_data, 8'h77);
        cyc();                                           // c3: idle gap
        mid(); chk("t3b_c3_winc", w_inc, 0);
        cyc();                                           // c4
        mid(); chk("t3b_c4_tx", tx_p_data, 8'hEF);
        cyc();                                           // c5
        mid(); chk("t3b_c5_tx", tx_p_data, 8'hBE);
        cyc();                                           // c6
        mid(); chk("t3b_c6_busy", busy, 0);
        exp_q = '{8'h77, 8'hEF, 8'hBE}; chk_log("t3b_log");

        // ---------------- T4: FIFO_FULL stall ----------------
        cyc(); push_log.delete();
        alu_vld = 1'b1; alu_out = 16'hA55A;              // c0
        cyc(); alu_vld = 1'b0;                           // c1
        cyc(); fifo_full = 1'b1;                         // c2..c6 full
        for (int i = 0; i < 5; i++) begin
            mid();
            chk($sformatf("t4_full%0d_winc", i), w_inc, 0);
            chk($sformatf("t4_full%0d_tx", i), tx_p_data, 8'h5A);
            cyc();
        end
        fifo_full = 1'b0;                                // c7
        mid(); chk("t4_c7_winc", w_inc, 1); chk("t4_c7_tx", tx_p_data, 8'h5A);
        cyc();                                           // c8
        mid(); chk("t4_c8_winc", w_inc, 1); chk("t4_c8_tx", tx_p_data, 8'hA5);
        cyc();                                           // c9
        mid(); chk("t4_c9_busy", busy, 0);
        exp_q = '{8'h5A, 8'hA5}; chk_log("t4_log");

        // ---------------- T5: overruns ----------------
        do_reset();
        alu_vld = 1'b1; alu_out = 16'hC3D2; fifo_full = 1'b1;   // c0
        cyc();                                           // c1: ALU overrun, RD captured
        alu_out = 16'hFFFF; rd_vld = 1'b1; rd_data = 8'h11;
        cyc();                                           // c2: both overrun
        alu_out = 16'hEEEE; rd_data = 8'h22;
`ifdef ARB_OVR_CNT_EN
        mid(); chk("t5_ovr_one", ovr_cnt, 1);
`endif
        cyc(); rd_vld = 1'b0;                            // c3, alu_vld still high
        mid(); chk("t5_hold_tx", tx_p_data, 8'hD2); chk("t5_hold_winc", w_inc, 0);
`ifdef ARB_OVR_CNT_EN
        chk("t5_ovr_three", ovr_cnt, 3);
`endif
        repeat (300) cyc();                              // 300 more ALU drops
        alu_vld = 1'b0;
        mid();
`ifdef ARB_OVR_CNT_EN
        chk("t5_ovr_sat", ovr_cnt, 255);
`endif
        chk("t5_sat_tx", tx_p_data, 8'hD2);
        cyc(); fifo_full = 1'b0;                         // release
        mid(); chk("t5_rel_tx_lo", tx_p_data, 8'hD2); chk("t5_rel_winc", w_inc, 1);
        cyc();
        mid(); chk("t5_rel_tx_hi", tx_p_data, 8'hC3);
        cyc(); cyc();
        mid(); chk("t5_rd_tx", tx_p_data, 8'h11);
        cyc();
        mid(); chk("t5_end_busy", busy, 0);
`ifdef ARB_OVR_CNT_EN
        chk("t5_ovr_kept", ovr_cnt, 255);
`endif
        exp_q = '{8'hD2, 8'hC3, 8'h11}; chk_log("t5_log");

        // ---------------- T6: reset during SEND_ALU_HI ----------------
        do_reset();
        alu_vld = 1'b1; alu_out = 16'h9876;              // c0
        cyc(); alu_vld = 1'b0;                           // c1
        cyc();                                           // c2
        mid(); chk("t6_c2_tx", tx_p_data, 8'h76);
        cyc();                                           // c3: high byte on the port
        chk("t6_c3_tx", tx_p_data, 8'h98); chk("t6_c3_winc", w_inc, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_winc", w_inc, 0);
        chk("t6_rst_tx",   tx_p_data, 0);
        chk("t6_rst_busy", busy, 0);
        cyc(); cyc();
        rst_n = 1'b1;
        repeat (5) cyc();
        mid(); chk("t6_after_busy", busy, 0); chk("t6_after_winc", w_inc, 0);
        exp_q = '{8'h76}; chk_log("t6_log");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
